// File: rtl/mod12_down_counter.sv
// Synchronous mod-12 down counter with load, borrow-chain cascade and terminal-count pulse.
// Define MOD12_DOWN_ONESHOT_EN to stop in DONE at zero instead of wrapping to 11.
module mod12_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout,
    output logic       tc,
    output logic       busy
);

`ifdef MOD12_DOWN_ONESHOT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_t;
`endif

    localparam logic [3:0] COUNT_MAX = 4'd11;

    state_t     state;
    logic [3:0] load_clamped;
    logic       at_zero;
    logic       dec;

    // Out-of-range start values saturate so q can never leave 0..11.
    assign load_clamped = (load_val > COUNT_MAX) ? COUNT_MAX : load_val;
    assign at_zero      = (q == 4'd0);
    assign dec          = en & bin & (state == RUN) & ~load;

    // The borrow is the terminal decrement itself, so a DONE state can never raise it.
    assign bout = dec & at_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= 4'd0;
            tc    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking default makes tc a one-cycle pulse; later assignments in this block win.
            tc <= 1'b0;
            if (load) begin
                state <= RUN;
                q     <= load_clamped;
                busy  <= 1'b1;
            end else if (dec) begin
                if (at_zero) begin
                    tc <= 1'b1;
`ifdef MOD12_DOWN_ONESHOT_EN
                    state <= DONE;
                    q     <= 4'd0;
                    busy  <= 1'b0;
`else
                    q     <= COUNT_MAX;
`endif
                end else begin
                    q <= q - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod12_down_counter.sv
// Directed self-checking bench for mod12_down_counter; follows MOD12_DOWN_ONESHOT_EN when defined.
module tb_mod12_down_counter;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       bin;
    logic [3:0] q;
    logic       bout;
    logic       tc;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    mod12_down_counter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .bin      (bin),
        .q        (q),
        .bout     (bout),
        .tc       (tc),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] eq, input logic etc, input logic ebusy);
        check({tag, ".q"}, q, eq);
        check({tag, ".tc"}, {3'b0, tc}, {3'b0, etc});
        check({tag, ".busy"}, {3'b0, busy}, {3'b0, ebusy});
    endtask

    logic [3:0] exp_q;

    initial begin
        rst = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b1; bin = 1'b1;

        // Reset asserted mid-cycle: outputs clear without a clock edge.
        #3 rst = 1'b1;
        #1;
        check_all("rst_async", 4'd0, 1'b0, 1'b0);
        check("rst_async.bout", {3'b0, bout}, 4'd0);
        tick();
        rst = 1'b0;

        // Idle: counting inputs are ignored until a load.
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("idle", 4'd0, 1'b0, 1'b0);
            check("idle.bout", {3'b0, bout}, 4'd0);
        end

        // Load 11 then count through the full sequence.
        load = 1'b1; load_val = 4'd11;
        tick();
        load = 1'b0;
        check_all("load11", 4'd11, 1'b0, 1'b1);
        exp_q = 4'd11;
`ifdef MOD12_DOWN_ONESHOT_EN
        for (int i = 0; i < 11; i++) begin
            check("cnt.bout", {3'b0, bout}, 4'd0);
            tick();
            exp_q = exp_q - 4'd1;
            check_all("cnt", exp_q, 1'b0, 1'b1);
        end
        #1 check("cnt_zero.bout", {3'b0, bout}, 4'd1);
`else
        for (int i = 0; i < 12; i++) begin
            #1 check("cnt.bout", {3'b0, bout}, (exp_q == 4'd0) ? 4'd1 : 4'd0);
            tick();
            exp_q = (exp_q == 4'd0) ? 4'd11 : exp_q - 4'd1;
            check_all("cnt", exp_q, exp_q == 4'd11, 1'b1);
        end
        // Run back down to zero for the priority test.
        for (int i = 0; i < 11; i++) tick();
        check_all("cnt_to_zero", 4'd0, 1'b0, 1'b1);
        #1 check("cnt_zero.bout", {3'b0, bout}, 4'd1);
`endif

        // Load at q=0 beats the terminal decrement: no bout, no tc.
        load = 1'b1; load_val = 4'd5;
        #1 check("prio.bout", {3'b0, bout}, 4'd0);
        tick();
        load = 1'b0;
        check_all("prio_load5", 4'd5, 1'b0, 1'b1);

        // Clamped load, then bin toggled: decrements only on bin=1 edges.
        load = 1'b1; load_val = 4'd14;
        tick();
        load = 1'b0;
        check_all("clamp14", 4'd11, 1'b0, 1'b1);
        exp_q = 4'd11;
        for (int i = 0; i < 22; i++) begin
            bin = i[0];
            tick();
            if (bin) exp_q = exp_q - 4'd1;
            check("cascade.q", q, exp_q);
        end
        check("cascade_end.q", q, 4'd0);
        bin = 1'b0;
        #1 check("cascade_bin0.bout", {3'b0, bout}, 4'd0);
        bin = 1'b1;
        #1 check("cascade_bin1.bout", {3'b0, bout}, 4'd1);

        // Load of 0 is legal; the next dec is terminal.
        load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0;
        #1 check("load0.bout", {3'b0, bout}, 4'd1);
        tick();
`ifdef MOD12_DOWN_ONESHOT_EN
        check_all("load0_term", 4'd0, 1'b1, 1'b0);
`else
        check_all("load0_term", 4'd11, 1'b1, 1'b1);
`endif
        // Reset while tc is pending clears it immediately.
        #2 rst = 1'b1;
        #1 check_all("rst_tc", 4'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Reset together with load: reset wins.
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        check("pre_rstload.q", q, 4'd7);
        #2 rst = 1'b1; load = 1'b1; load_val = 4'd9;
        #1 check_all("rst_load", 4'd0, 1'b0, 1'b0);
        tick();
        check_all("rst_load_edge", 4'd0, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("rst_load_idle", 4'd0, 1'b0, 1'b0);
        end

        // Reset mid-count: load 9, count to 4, pulse reset.
        load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_all("mid_count", 4'd4, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 check_all("mid_rst", 4'd0, 1'b0, 1'b0);
        check("mid_rst.bout", {3'b0, bout}, 4'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("mid_rst_idle", 4'd0, 1'b0, 1'b0);
        end

`ifdef MOD12_DOWN_ONESHOT_EN
        // One-shot: load 3 -> 3,2,1,0 then DONE with a single tc.
        load = 1'b1; load_val = 4'd3;
        tick();
        load = 1'b0;
        check_all("os_load3", 4'd3, 1'b0, 1'b1);
        tick(); check_all("os_2", 4'd2, 1'b0, 1'b1);
        tick(); check_all("os_1", 4'd1, 1'b0, 1'b1);
        tick(); check_all("os_0", 4'd0, 1'b0, 1'b1);
        #1 check("os_0.bout", {3'b0, bout}, 4'd1);
        tick(); check_all("os_term", 4'd0, 1'b1, 1'b0);
        check("os_done.bout", {3'b0, bout}, 4'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("os_done", 4'd0, 1'b0, 1'b0);
            check("os_done.bout", {3'b0, bout}, 4'd0);
        end
        load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0;
        check_all("os_reload", 4'd2, 1'b0, 1'b1);
        tick(); check_all("os_reload_dec", 4'd1, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod12_down_counter.md
# mod12_down_counter

Synchronous mod-12 down counter, the counting-direction complement of the team's ripple mod-12 up counter. Loads a start value, decrements 11→0 on qualified clock edges and flags each terminal count, so it can serve as a countdown timer or as the borrow-chained lower digit of a multi-digit down counter. All flops share one clock; there is no ripple clocking, so outputs settle on the same edge.

## Interface
- No parameters; modulus fixed at 12, count width fixed at 4.
- clk  in  1  rising-edge clock for all state
- rst  in  1  reset: rst, asynchronous, active-high
- load  in  1  synchronous load strobe; highest priority after rst
- load_val  in  4  start value; values 12–15 clamp to 11
- en  in  1  count enable
- bin  in  1  borrow-in / cascade enable; tie high when standalone
- q  out  4  current count, always 0..11
- bout  out  1  combinational borrow-out; feeds bin of the next digit
- tc  out  1  registered terminal-count pulse, one cycle wide
- busy  out  1  high while state is RUN

## Operation
- Decrement condition: dec = en & bin & (state == RUN) & ~load.
- FSM states:
  - IDLE: reset state; q holds.
  - RUN: counting.
  - DONE: exists only with the macro; q holds at 0.
- FSM transitions:
  - Any state, load=1 → RUN; q ← min(load_val, 11).
  - RUN, dec, q≠0 → RUN; q ← q−1.
  - RUN, dec, q=0 → wrap or stop; see Configuration.
  - IDLE and DONE ignore en and bin.
- bout = en & bin & (state == RUN) & (q == 0) & ~load. It is asserted in the same cycle in which the wrap or stop is taken.
- tc is set to 1 on the edge that performs the 0 → wrap/stop transition. It clears on the next edge.
- busy = (state == RUN). It is a registered decode, with no combinational path from inputs.
- Arithmetic:
  - q is 4 bits unsigned.
  - q never holds 12–15, including after a clamped load.
  - Decrement never underflows to 15.
- Load of 0 is legal: the next dec produces the wrap/stop with bout=1.

## Timing
- Reset values, applied immediately while rst=1 and independent of clk:
  - q=0, state=IDLE, tc=0, busy=0.
  - bout=0.
- Load latency: q, busy and state are valid 1 cycle after the load edge.
- Count latency: q changes on the first rising edge where dec=1.
- tc is high for exactly the cycle following the terminal edge.
- bout is combinational from en, bin, load, q and state, with zero latency.
- Simultaneous events:
  - rst beats everything.
  - load beats dec; no tc is generated on a load edge, even when q=0.
- rst mid-count: the count is abandoned, outputs go to reset values, and a pending tc pulse is cleared.
- rst deassertion: the block stays in IDLE until the first load.

## Configuration
- MOD12_DOWN_ONESHOT_EN defined (one-shot timer):
  - RUN, dec, q=0 → DONE; q stays 0; tc pulses; busy falls one cycle after the terminal edge.
  - DONE holds until load or rst.
  - bout is asserted only on the terminal edge, never while in DONE.
- MOD12_DOWN_ONESHOT_EN undefined (free-running modulus):
  - RUN, dec, q=0 → RUN; q ← 11; tc pulses.
  - DONE is not implemented; busy stays 1 after the first load until rst.

## Test plan
- Reset and idle: assert rst mid-cycle → q=0, tc=0, busy=0, bout=0 immediately; hold en=bin=1 with no load for 20 cycles → q stays 0, tc never asserts.
- Full count, macro undefined: load 11, then en=bin=1 → q steps 11,10,…,0,11. bout=1 in the q=0 cycle, tc=1 in the cycle q=11, busy constantly 1.
- Clamp and cascade: load_val=14 → q=11. Toggle bin every other cycle → q decrements only on edges with bin=1, reaching 0 after 22 cycles.
- Priority: load=1 with load_val=5 while q=0 and en=bin=1 → next q=5, tc=0, bout=0 that cycle. rst together with load → q=0, IDLE.
- One-shot, macro defined: load 3, en=bin=1 → q sequence 3,2,1,0,0,0…; tc high once, 4 cycles after load; busy low from that cycle onward. A later load of 2 → RUN resumes.
- Reset mid-count: load 9, count to 4, pulse rst for one cycle → q=0 and IDLE immediately. The following en=bin=1 cycles leave q=0 until the next load.
